// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: FSM state encoding, transfer direction
// and a couple of small constants/helpers used by the top level.
package i2c_target_pkg;

   // FSM state encoding kept as plain constants so older tools can consume it.
   typedef logic [2:0] i2c_target_state_t;

   localparam i2c_target_state_t S_IDLE      = 3'd0;
   localparam i2c_target_state_t S_ADDR      = 3'd1;
   localparam i2c_target_state_t S_ACK_ADDR  = 3'd2;
   localparam i2c_target_state_t S_WR_DATA   = 3'd3;
   localparam i2c_target_state_t S_ACK_WR    = 3'd4;
   localparam i2c_target_state_t S_RD_DATA   = 3'd5;
   localparam i2c_target_state_t S_ACK_RD    = 3'd6;
   localparam i2c_target_state_t S_WAIT_STOP = 3'd7;

   // Direction carried in bit 0 of the address byte.
   typedef enum logic {
      I2C_WRITE = 1'b0,
      I2C_READ  = 1'b1
   } i2c_transaction_t;

   // Byte returned to the controller when no read data is available.
   localparam logic [7:0] UNDERRUN_FILL = 8'hFF;

   // True when the upper seven bits of an address byte select this target.
   function automatic logic addr_match(input logic [7:0] addr_byte,
                                       input logic [6:0] target);
      return (addr_byte[7:1] == target);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for an asynchronous bus line followed by an
// edge-detect register. Strobes are single-cycle and aligned with o_level.
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Resync the line and keep the previous synced value for edge detection;
   // reset to the idle (high) bus level so no spurious edge follows reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint answering one fixed 7-bit address. The bus is
// oversampled on clk; write bytes leave on a ready/valid stream and read
// bytes are pulled from a ready/valid stream. SDA is only ever pulled low.
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic       o_valid,
   input  logic       o_ready,
   output logic [7:0] o_data,
   input  logic       i_valid,
   output logic       i_ready,
   input  logic [7:0] i_data,
   output logic       busy,
   output logic       underrun
);

   logic w_scl_level;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_sda_level;
   logic w_sda_rise;
   logic w_sda_fall;

   i2c_line_sync u_scl_sync (
      .clk     (clk),
      .rst     (rst),
      .i_line  (scl),
      .o_level (w_scl_level),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk     (clk),
      .rst     (rst),
      .i_line  (sda),
      .o_level (w_sda_level),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   i2c_target_state_t r_state;
   i2c_transaction_t  r_rw;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_shift;
   logic [7:0]        r_tx;
   logic              r_sda_oe;
   logic              r_busy;
   logic              r_o_valid;
   logic [7:0]        r_o_data;
   logic              r_i_ready;
   logic              r_underrun;
   logic              r_phase;   // ACK states: 0 = before first scl_fall, 1 = after
   logic              r_nack;    // current write byte was dropped and gets NACKed

   logic       w_start;
   logic       w_stop;
   logic [7:0] w_rx_byte;
   logic [7:0] w_load_byte;

   // Bus conditions: SDA edge while SCL is high.
   assign w_start = w_sda_fall & w_scl_level;
   assign w_stop  = w_sda_rise & w_scl_level;

   // Byte as it will look once the bit being sampled now is shifted in.
   assign w_rx_byte = {r_shift[6:0], w_sda_level};

   // Next read byte, or the fill pattern when the source has nothing.
   assign w_load_byte = i_valid ? i_data : UNDERRUN_FILL;

   // Bus protocol FSM; START/STOP override every data-path action.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rw       <= I2C_WRITE;
         r_bit_cnt  <= 3'd7;
         r_shift    <= 8'h00;
         r_tx       <= 8'h00;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_o_valid  <= 1'b0;
         r_o_data   <= 8'h00;
         r_i_ready  <= 1'b0;
         r_underrun <= 1'b0;
         r_phase    <= 1'b0;
         r_nack     <= 1'b0;
      end else begin
         r_i_ready  <= 1'b0;
         r_underrun <= 1'b0;

         // The consumer may drain the output register in any bus state.
         if (r_o_valid && o_ready) begin
            r_o_valid <= 1'b0;
         end

         if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= 3'd7;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_phase   <= 1'b0;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_phase   <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_sda_oe <= 1'b0;
               end

               S_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift <= w_rx_byte;
                     if (r_bit_cnt == 3'd0) begin
                        if (addr_match(w_rx_byte, TARGET_ADDR)) begin
                           r_state <= S_ACK_ADDR;
                           r_busy  <= 1'b1;
                           r_rw    <= i2c_transaction_t'(w_rx_byte[0]);
                           r_phase <= 1'b0;
                        end else begin
                           r_state <= S_WAIT_STOP;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                     end
                  end
               end

               S_ACK_ADDR: begin
                  if (w_scl_fall) begin
                     if (!r_phase) begin
                        r_sda_oe <= 1'b1;
                        r_phase  <= 1'b1;
                     end else begin
                        r_phase   <= 1'b0;
                        r_bit_cnt <= 3'd7;
                        if (r_rw == I2C_WRITE) begin
                           r_sda_oe <= 1'b0;
                           r_state  <= S_WR_DATA;
                        end else begin
                           r_tx       <= w_load_byte;
                           r_i_ready  <= i_valid;
                           r_underrun <= ~i_valid;
                           r_sda_oe   <= ~w_load_byte[7];
                           r_state    <= S_RD_DATA;
                        end
                     end
                  end
               end

               S_WR_DATA: begin
                  if (w_scl_rise) begin
                     r_shift <= w_rx_byte;
                     if (r_bit_cnt == 3'd0) begin
                        r_state <= S_ACK_WR;
                        r_phase <= 1'b0;
                        if (!r_o_valid) begin
                           r_o_data  <= w_rx_byte;
                           r_o_valid <= 1'b1;
                           r_nack    <= 1'b0;
                        end else begin
                           r_nack    <= 1'b1;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                     end
                  end
               end

               S_ACK_WR: begin
                  if (w_scl_fall) begin
                     if (!r_phase) begin
                        r_sda_oe <= ~r_nack;
                        r_phase  <= 1'b1;
                     end else begin
                        r_sda_oe  <= 1'b0;
                        r_phase   <= 1'b0;
                        r_bit_cnt <= 3'd7;
                        r_state   <= r_nack ? S_WAIT_STOP : S_WR_DATA;
                     end
                  end
               end

               S_RD_DATA: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt == 3'd0) begin
                        r_sda_oe <= 1'b0;
                        r_phase  <= 1'b0;
                        r_state  <= S_ACK_RD;
                     end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                        r_sda_oe  <= ~r_tx[6];
                        r_tx      <= {r_tx[6:0], 1'b1};
                     end
                  end
               end

               S_ACK_RD: begin
                  if (!r_phase) begin
                     if (w_scl_rise) begin
                        if (w_sda_level) begin
                           r_state <= S_WAIT_STOP;
                        end else begin
                           r_phase <= 1'b1;
                        end
                     end
                  end else if (w_scl_fall) begin
                     r_phase    <= 1'b0;
                     r_bit_cnt  <= 3'd7;
                     r_tx       <= w_load_byte;
                     r_i_ready  <= i_valid;
                     r_underrun <= ~i_valid;
                     r_sda_oe   <= ~w_load_byte[7];
                     r_state    <= S_RD_DATA;
                  end
               end

               S_WAIT_STOP: begin
                  r_sda_oe <= 1'b0;
               end

               default: begin
                  r_state  <= S_IDLE;
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sda      = r_sda_oe ? 1'b0 : 1'bz;
   assign o_valid  = r_o_valid;
   assign o_data   = r_o_data;
   assign i_ready  = r_i_ready;
   assign busy     = r_busy;
   assign underrun = r_underrun;

endmodule
